debounce_bank: RTL and testbench

//  Multi-channel, parametrised successor to the single-button debouncer. Each of N_CH raw inputs
//  (buttons, switches) is synchronised, sampled at a divided tick rate, and accepted only after

---
 rtl/debounce_bank_pkg.sv | 16 +
 rtl/debounce_channel.sv | 56 +++++
 rtl/debounce_bank.sv | 60 ++++++
 tb/tb_debounce_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_bank_pkg.sv
// Shared constants for the debounce bank: board defaults, reset level and width helper.
// Board default: one sample per millisecond at 100 MHz.
package debounce_bank_pkg;

   localparam int   BOARD_CLK_HZ         = 100_000_000;
   localparam int   BOARD_CLK_DIV        = BOARD_CLK_HZ / 1000;
   localparam int   DEF_STABLE_SAMPLES   = 4;
   localparam int   DEF_CLK_DIV          = 1;
   localparam logic DEF_RESET_VAL        = 1'b0;

   // Counter width that never collapses to zero bits.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, agreement counter, clean level and edge pulses.
module debounce_channel
   import debounce_bank_pkg::*;
#(
   parameter int   STABLE_SAMPLES = DEF_STABLE_SAMPLES,
   parameter logic RESET_VAL      = DEF_RESET_VAL
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic state,
   output logic rise,
   output logic fall,
   output logic flip_nxt
);

   localparam int            CW       = cnt_w(STABLE_SAMPLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          differ;

   assign differ   = (sync2 != state);
   // The flip is decided combinationally so the bank can register any_change with the pulses.
   assign flip_nxt = tick & differ & (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= RESET_VAL;
         sync2 <= RESET_VAL;
         state <= RESET_VAL;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= flip_nxt & sync2;
         fall  <= flip_nxt & ~sync2;
         if (tick) begin
            if (!differ) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               state <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: shared sample-tick divider feeding N_CH independent channels.
module debounce_bank
   import debounce_bank_pkg::*;
#(
   parameter int   N_CH           = 4,
   parameter int   CLK_DIV        = DEF_CLK_DIV,
   parameter int   STABLE_SAMPLES = DEF_STABLE_SAMPLES,
   parameter logic RESET_VAL      = DEF_RESET_VAL
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] raw,
   output logic [N_CH-1:0] state,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            any_change
);

   localparam int            DW       = cnt_w(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [N_CH-1:0] flip_nxt;

   // With CLK_DIV=1 the divider is pinned at 0 and tick stays high.
   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         any_change <= 1'b0;
      end else begin
         div_cnt    <= tick ? '0 : div_cnt + DW'(1);
         any_change <= |flip_nxt;
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_CH; g++) begin : g_ch
         debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .RESET_VAL      (RESET_VAL)
         ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .raw      (raw[g]),
            .state    (state[g]),
            .rise     (rise[g]),
            .fall     (fall[g]),
            .flip_nxt (flip_nxt[g])
         );
      end
   endgenerate

   a_no_dual_edge : assert property (@(posedge clk) disable iff (!rst_n) !(|(rise & fall)));

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised + directed bench for debounce_bank against a sliding-window reference model.
module tb_debounce_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] raw = 4'h0;
   logic [3:0] raw5 = 4'h0;
   logic [3:0] state, rise, fall, state5, rise5, fall5;
   logic       any_change, any_change5;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   debounce_bank #(.N_CH(4), .CLK_DIV(1), .STABLE_SAMPLES(4), .RESET_VAL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .raw(raw), .state(state), .rise(rise), .fall(fall),
      .any_change(any_change));

   debounce_bank #(.N_CH(4), .CLK_DIV(5), .STABLE_SAMPLES(4), .RESET_VAL(1'b0)) dut5 (
      .clk(clk), .rst_n(rst_n), .raw(raw5), .state(state5), .rise(rise5), .fall(fall5),
      .any_change(any_change5));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: input is delayed two clocks, sampled every div-th clock since reset; a channel
   // flips when its last 4 samples (all taken since the last flip/reset) all disagree with it.
   int         m_div [2];
   logic [3:0] m_d1 [2], m_d2 [2], m_state [2], m_rise [2], m_fall [2];
   logic       m_any [2];
   logic [7:0] m_hist [2][4];
   int         m_n [2][4];

   task automatic mstep(input int i, input int div, input logic [3:0] r);
      logic       tk;
      logic [3:0] smp, want;
      if (!rst_n) begin
         m_div[i] = 0; m_d1[i] = 4'h0; m_d2[i] = 4'h0; m_state[i] = 4'h0;
         m_rise[i] = 4'h0; m_fall[i] = 4'h0; m_any[i] = 1'b0;
         for (int c = 0; c < 4; c++) begin m_hist[i][c] = 8'h0; m_n[i][c] = 0; end
      end else begin
         tk  = (m_div[i] % div) == div - 1;
         m_div[i] = m_div[i] + 1;
         smp = m_d2[i];
         m_d2[i] = m_d1[i];
         m_d1[i] = r;
         m_rise[i] = 4'h0; m_fall[i] = 4'h0;
         if (tk) begin
            for (int c = 0; c < 4; c++) begin
               m_hist[i][c] = {m_hist[i][c][6:0], smp[c]};
               m_n[i][c]++;
               want = m_state[i][c] ? 4'h0 : 4'hF;
               if (m_n[i][c] >= 4 && m_hist[i][c][3:0] == want) begin
                  m_state[i][c] = ~m_state[i][c];
                  if (m_state[i][c]) m_rise[i][c] = 1'b1; else m_fall[i][c] = 1'b1;
                  m_n[i][c] = 0;
               end
            end
         end
         m_any[i] = |(m_rise[i] | m_fall[i]);
      end
   endtask

   always @(posedge clk) begin
      mstep(0, 1, raw);
      mstep(1, 5, raw5);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m1_state", {28'h0, state}, {28'h0, m_state[0]});
         chk("m1_rise",  {28'h0, rise},  {28'h0, m_rise[0]});
         chk("m1_fall",  {28'h0, fall},  {28'h0, m_fall[0]});
         chk("m1_any",   {31'h0, any_change}, {31'h0, m_any[0]});
         chk("m5_state", {28'h0, state5}, {28'h0, m_state[1]});
         chk("m5_rise",  {28'h0, rise5},  {28'h0, m_rise[1]});
         chk("m5_fall",  {28'h0, fall5},  {28'h0, m_fall[1]});
         chk("m5_any",   {31'h0, any_change5}, {31'h0, m_any[1]});
      end
   end

   int cnt_r [4], cnt_f [4], cnt_r5 [4], cnt_f5 [4];

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      for (int c = 0; c < 4; c++) begin cnt_r[c] = 0; cnt_f[c] = 0; cnt_r5[c] = 0; cnt_f5[c] = 0; end
   endtask

   task automatic run_cnt(input int n);
      repeat (n) begin
         cyc(1);
         for (int c = 0; c < 4; c++) begin
            cnt_r[c] += int'(rise[c]);  cnt_f[c] += int'(fall[c]);
            cnt_r5[c] += int'(rise5[c]); cnt_f5[c] += int'(fall5[c]);
         end
      end
   endtask

   task automatic do_reset(input logic [3:0] r, input logic [3:0] r5);
      rst_n = 1'b0; raw = r; raw5 = r5;
      cyc(2);
      chk("rst_state", {28'h0, state}, 32'h0);
      chk("rst_rise",  {28'h0, rise},  32'h0);
      chk("rst_any",   {31'h0, any_change}, 32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      int hold [4], hold5 [4];
      @(posedge clk);
      chk_en = 1;

      // 1: raw high through reset, clean level arrives on 6th edge after release
      do_reset(4'hF, 4'h0);
      cyc(1);
      chk("t1_rel_state", {28'h0, state}, 32'h0);
      chk("t1_rel_rise",  {28'h0, rise},  32'h0);
      cyc(4);
      chk("t1_e5_state", {28'h0, state}, 32'h0);
      cyc(1);
      chk("t1_e6_state", {28'h0, state}, 32'hF);
      chk("t1_e6_rise",  {28'h0, rise},  32'hF);
      cyc(1);
      chk("t1_e7_rise",  {28'h0, rise},  32'h0);

      // 2: bounce on ch0, then settle high
      do_reset(4'h0, 4'h0);
      cyc(6);
      clr_cnt();
      repeat (5) begin
         raw[0] = 1'b1; run_cnt(2);
         raw[0] = 1'b0; run_cnt(2);
      end
      raw[0] = 1'b1;
      run_cnt(5);
      chk("t2_e5_state0", {31'h0, state[0]}, 32'h0);
      run_cnt(1);
      chk("t2_e6_state0", {31'h0, state[0]}, 32'h1);
      run_cnt(6);
      chk("t2_rise0_cnt", cnt_r[0], 1);
      chk("t2_fall0_cnt", cnt_f[0], 0);

      // 3: single-cycle glitch on ch1
      clr_cnt();
      raw[1] = 1'b1; cyc(1); raw[1] = 1'b0;
      run_cnt(12);
      chk("t3_state1", {31'h0, state[1]}, 32'h0);
      chk("t3_rise1",  cnt_r[1], 0);
      chk("t3_fall1",  cnt_f[1], 0);

      // 4: simultaneous rise on ch2 and fall on ch3
      do_reset(4'h8, 4'h0);
      cyc(8);
      chk("t4_pre_state", {28'h0, state}, 32'h8);
      raw = 4'h4;
      cyc(5);
      chk("t4_e5_any", {31'h0, any_change}, 32'h0);
      cyc(1);
      chk("t4_rise", {28'h0, rise}, 32'h4);
      chk("t4_fall", {28'h0, fall}, 32'h8);
      chk("t4_any",  {31'h0, any_change}, 32'h1);
      cyc(1);
      chk("t4_any_off", {31'h0, any_change}, 32'h0);

      // 5: divided tick on the CLK_DIV=5 instance, plus an unsampled blip
      do_reset(4'h0, 4'h1);
      cyc(19);
      chk("t5_e19_state", {31'h0, state5[0]}, 32'h0);
      cyc(1);
      chk("t5_e20_state", {31'h0, state5[0]}, 32'h1);
      chk("t5_e20_rise",  {31'h0, rise5[0]}, 32'h1);
      cyc(3);
      clr_cnt();
      raw5[0] = 1'b0; run_cnt(3); raw5[0] = 1'b1;
      run_cnt(20);
      chk("t5_blip_state", {31'h0, state5[0]}, 32'h1);
      chk("t5_blip_fall",  cnt_f5[0], 0);

      // 6: reset after 3 counted samples discards the count
      do_reset(4'hF, 4'h0);
      cyc(5);
      rst_n = 1'b0;
      cyc(1);
      chk("t6_rst_state", {28'h0, state}, 32'h0);
      chk("t6_rst_rise",  {28'h0, rise},  32'h0);
      rst_n = 1'b1;
      cyc(5);
      chk("t6_e5_state", {28'h0, state}, 32'h0);
      cyc(1);
      chk("t6_e6_state", {28'h0, state}, 32'hF);

      // random phase, checked every cycle against the model
      for (int c = 0; c < 4; c++) begin hold[c] = 0; hold5[c] = 0; end
      repeat (3000) begin
         @(negedge clk); #1;
         rst_n = ($urandom_range(0, 399) != 0);
         for (int c = 0; c < 4; c++) begin
            if (hold[c] == 0) begin raw[c] = 1'($urandom); hold[c] = $urandom_range(1, 7); end
            else hold[c]--;
            if (hold5[c] == 0) begin raw5[c] = 1'($urandom); hold5[c] = $urandom_range(1, 30); end
            else hold5[c]--;
         end
      end
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
